// File: rtl/odd_seq_checker.sv
// Monitors an odd-counter stream: every sample must be odd and step by +2 (mod 2^WIDTH).
// Locks after LOCK_CNT good samples and counts/records errors only while locked; all outputs registered.
module odd_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             sticky_err,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] expected
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V  = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LOSS_V  = MISS_W'(LOSS_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;
    localparam logic [WIDTH-1:0]  TWO     = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              sticky_err_q, sticky_err_d;
    logic [WIDTH-1:0]  first_bad_q, first_bad_d;
    logic [WIDTH-1:0]  expected_q, expected_d;

    logic              odd;
    logic              good;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;

    assign odd      = count[0];
    assign good     = odd && (count == expected_q);
    assign run_inc  = run_q + RUN_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        miss_d       = miss_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        sticky_err_d = sticky_err_q;
        first_bad_d  = first_bad_q;
        expected_d   = expected_q;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (odd) begin
                        expected_d = count + TWO;
                        run_d      = RUN_W'(1);
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (good) begin
                        expected_d = expected_q + TWO;
                        if (run_inc == LOCK_V) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (odd) begin
                        run_d      = RUN_W'(1);
                        expected_d = count + TWO;
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                LOCKED: begin
                    expected_d = expected_q + TWO;
                    if (good) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d  = 1'b1;
                        sticky_err_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
                        if (!sticky_err_q) first_bad_d = count;
                        // Free-run past isolated glitches; only a sustained run of misses drops lock.
                        if (miss_inc == LOSS_V) begin
                            state_d    = IDLE;
                            locked_d   = 1'b0;
                            miss_d     = '0;
                            expected_d = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear overrides any same-cycle error bookkeeping, but not the pulse or FSM.
        if (clr) begin
            err_cnt_d    = '0;
            sticky_err_d = 1'b0;
            first_bad_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            run_q        <= '0;
            miss_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
            sticky_err_q <= 1'b0;
            first_bad_q  <= '0;
            expected_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
            sticky_err_q <= sticky_err_d;
            first_bad_q  <= first_bad_d;
            expected_q   <= expected_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign sticky_err = sticky_err_q;
    assign first_bad  = first_bad_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Bench for odd_seq_checker: vector table, directed corner sequences and a random stream,
// all compared against a behavioural model; a second instance runs with a 2-bit error counter.
module tb_odd_seq_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] count;

    logic       locked, err_pulse, sticky_err;
    logic [7:0] err_cnt, first_bad, expected;
    logic       locked2, err_pulse2, sticky_err2;
    logic [1:0] err_cnt2;
    logic [7:0] first_bad2, expected2;

    always #5 clk = ~clk;

    odd_seq_checker #(.WIDTH(8), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .count(count), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .sticky_err(sticky_err), .first_bad(first_bad), .expected(expected)
    );

    odd_seq_checker #(.WIDTH(8), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .count(count), .clr(clr),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
        .sticky_err(sticky_err2), .first_bad(first_bad2), .expected(expected2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: m_run counts good samples while hunting (0 = nothing seen yet).
    int m_locked, m_run, m_miss, m_exp, m_err, m_sticky, m_first, m_pulse;

    typedef struct {
        bit en;
        int cnt;
        bit clr;
        int locked;
        int pulse;
        int err;
        int sticky;
        int first;
        int expv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_miss = 0; m_exp = 0;
        m_err = 0; m_sticky = 0; m_first = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit e, input int c, input bit cl);
        int  v;
        bit  good;
        v       = c & 255;
        m_pulse = 0;
        if (e) begin
            good = (v % 2 == 1) && (v == m_exp);
            if (m_locked != 0) begin
                m_exp = (m_exp + 2) % 256;
                if (good) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    m_err++;
                    if (m_sticky == 0) m_first = v;
                    m_sticky = 1;
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_locked = 0; m_miss = 0; m_exp = 0;
                    end
                end
            end else if (m_run == 0) begin
                if (v % 2 == 1) begin m_run = 1; m_exp = (v + 2) % 256; end
            end else if (good) begin
                m_run++;
                m_exp = (m_exp + 2) % 256;
                if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
            end else if (v % 2 == 1) begin
                m_run = 1; m_exp = (v + 2) % 256;
            end else begin
                m_run = 0;
            end
        end
        if (cl) begin m_err = 0; m_sticky = 0; m_first = 0; end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":locked"},     int'(locked),      m_locked);
        chk({tag, ":err_pulse"},  int'(err_pulse),   m_pulse);
        chk({tag, ":err_cnt"},    int'(err_cnt),     sat(m_err, 255));
        chk({tag, ":sticky"},     int'(sticky_err),  m_sticky);
        chk({tag, ":first_bad"},  int'(first_bad),   m_first);
        chk({tag, ":expected"},   int'(expected),    m_exp);
        chk({tag, ":locked2"},    int'(locked2),     m_locked);
        chk({tag, ":err_pulse2"}, int'(err_pulse2),  m_pulse);
        chk({tag, ":err_cnt2"},   int'(err_cnt2),    sat(m_err, 3));
        chk({tag, ":sticky2"},    int'(sticky_err2), m_sticky);
        chk({tag, ":first_bad2"}, int'(first_bad2),  m_first);
        chk({tag, ":expected2"},  int'(expected2),   m_exp);
    endtask

    task automatic drive(input bit e, input int c, input bit cl, input string tag);
        en    = e;
        count = c[7:0];
        clr   = cl;
        @(posedge clk);
        #1;
        model_step(e, c, cl);
        check_model(tag);
    endtask

    task automatic do_reset();
        en = 1'b0; clr = 1'b0; count = 8'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_model("reset");
        rst_n = 1'b1;
    endtask

    task automatic lock_at(input int start);
        for (int i = 0; i < LOCK; i++) drive(1'b1, (start + 2 * i) % 256, 1'b0, "lock");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Vector table from reset: even ignored in IDLE, lock on 1,3,5,7, glitch, clear, new error.
        tbl[0]  = '{1'b1, 4,  1'b0, 0, 0, 0, 0, 0,  0};
        tbl[1]  = '{1'b1, 1,  1'b0, 0, 0, 0, 0, 0,  3};
        tbl[2]  = '{1'b1, 3,  1'b0, 0, 0, 0, 0, 0,  5};
        tbl[3]  = '{1'b1, 5,  1'b0, 0, 0, 0, 0, 0,  7};
        tbl[4]  = '{1'b1, 7,  1'b0, 1, 0, 0, 0, 0,  9};
        tbl[5]  = '{1'b1, 8,  1'b0, 1, 1, 1, 1, 8,  11};
        tbl[6]  = '{1'b1, 11, 1'b0, 1, 0, 1, 1, 8,  13};
        tbl[7]  = '{1'b0, 99, 1'b0, 1, 0, 1, 1, 8,  13};
        tbl[8]  = '{1'b1, 13, 1'b0, 1, 0, 1, 1, 8,  15};
        tbl[9]  = '{1'b1, 15, 1'b1, 1, 0, 0, 0, 0,  17};
        tbl[10] = '{1'b1, 16, 1'b0, 1, 1, 1, 1, 16, 19};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].en, tbl[i].cnt, tbl[i].clr, "tblmodel");
            chk("tbl:locked",    int'(locked),     tbl[i].locked);
            chk("tbl:err_pulse", int'(err_pulse),  tbl[i].pulse);
            chk("tbl:err_cnt",   int'(err_cnt),    tbl[i].err);
            chk("tbl:sticky",    int'(sticky_err), tbl[i].sticky);
            chk("tbl:first_bad", int'(first_bad),  tbl[i].first);
            chk("tbl:expected",  int'(expected),   tbl[i].expv);
        end

        // Wrap 255 -> 1 is a legal step.
        do_reset();
        lock_at(243);
        chk("wrap:locked_in", int'(locked), 1);
        chk("wrap:exp_in", int'(expected), 251);
        foreach (tbl[i]) begin end
        drive(1'b1, 251, 1'b0, "wrap");
        drive(1'b1, 253, 1'b0, "wrap");
        drive(1'b1, 255, 1'b0, "wrap");
        chk("wrap:pulse255", int'(err_pulse), 0);
        drive(1'b1, 1, 1'b0, "wrap");
        chk("wrap:pulse1", int'(err_pulse), 0);
        drive(1'b1, 3, 1'b0, "wrap");
        chk("wrap:locked", int'(locked), 1);
        chk("wrap:expected", int'(expected), 5);
        chk("wrap:err_cnt", int'(err_cnt), 0);

        // Three consecutive misses drop lock; then relock on a fresh stream.
        drive(1'b1, 0, 1'b0, "loss");
        drive(1'b1, 0, 1'b0, "loss");
        chk("loss:still_locked", int'(locked), 1);
        drive(1'b1, 0, 1'b0, "loss");
        chk("loss:locked", int'(locked), 0);
        chk("loss:expected", int'(expected), 0);
        chk("loss:err_cnt", int'(err_cnt), 3);
        drive(1'b1, 21, 1'b0, "relock");
        drive(1'b1, 23, 1'b0, "relock");
        drive(1'b1, 25, 1'b0, "relock");
        chk("relock:early", int'(locked), 0);
        drive(1'b1, 27, 1'b0, "relock");
        chk("relock:locked", int'(locked), 1);
        chk("relock:expected", int'(expected), 29);
        chk("relock:err_hold", int'(err_cnt), 3);

        // Saturation of the 2-bit counter and clear beating a same-cycle error.
        do_reset();
        lock_at(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, m_exp + 1, 1'b0, "sat");
            drive(1'b1, m_exp, 1'b0, "sat");
        end
        chk("sat:err_cnt2", int'(err_cnt2), 3);
        chk("sat:err_cnt", int'(err_cnt), 5);
        chk("sat:locked2", int'(locked2), 1);
        drive(1'b1, m_exp + 1, 1'b1, "clrerr");
        chk("clrerr:err_cnt2", int'(err_cnt2), 0);
        chk("clrerr:sticky2", int'(sticky_err2), 0);
        chk("clrerr:pulse2", int'(err_pulse2), 1);
        chk("clrerr:first2", int'(first_bad2), 0);

        // Asynchronous reset mid-lock, then idle stretches.
        do_reset();
        lock_at(1);
        drive(1'b1, 100, 1'b0, "arst");
        drive(1'b1, m_exp, 1'b0, "arst");
        drive(1'b1, 100, 1'b0, "arst");
        chk("arst:pre_err", int'(err_cnt), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst:locked",   int'(locked),     0);
        chk("arst:err_cnt",  int'(err_cnt),    0);
        chk("arst:sticky",   int'(sticky_err), 0);
        chk("arst:first",    int'(first_bad),  0);
        chk("arst:expected", int'(expected),   0);
        chk("arst:pulse",    int'(err_pulse),  0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 7, 1'b0, "idle_rst");
        lock_at(41);
        drive(1'b1, 60, 1'b0, "stretch");
        for (int i = 0; i < 6; i++) drive(1'b0, $urandom_range(0, 255), 1'b0, "stretch");
        chk("stretch:expected", int'(expected), 51);
        chk("stretch:err_cnt", int'(err_cnt), 1);
        chk("stretch:pulse", int'(err_pulse), 0);

        // Random stream, mostly in-sequence with glitches, evens, gaps and rare clears.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int  r;
            int  c;
            bit  e;
            bit  cl;
            e = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 99);
            if (r < 80)      c = m_exp;
            else if (r < 90) c = $urandom_range(0, 255) | 1;
            else             c = $urandom_range(0, 255);
            cl = ($urandom_range(0, 49) == 0);
            drive(e, c, cl, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
